// File: rtl/mdr_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : mdr_mem_port
// Description : Memory data register with a req/ack handshake engine for
//               byte, halfword and full-width loads and stores.
// Revision    : 1.0 - initial release
// ============================================================================
module mdr_mem_port #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = DATA_WIDTH / 8,
    parameter int LSB_W      = $clog2(LANES),
    parameter int TIMEOUT    = 16
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  mdr_in,
    input  logic                  mdr_out,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  bus_out_en,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            size,
    input  logic [LSB_W-1:0]      addr_lsb,
    input  logic                  unsigned_ld,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [LANES-1:0]      mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD_REQ = 2'd1,
        S_WR_REQ = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_data, w_data_nxt;
    logic                    r_req, w_req_nxt;
    logic                    r_we, w_we_nxt;
    logic [LANES-1:0]        r_be, w_be_nxt;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_err, w_err_nxt;
    logic [1:0]              r_size, w_size_nxt;
    logic [LSB_W-1:0]        r_lsb, w_lsb_nxt;
    logic                    r_unsigned, w_unsigned_nxt;

    logic                    w_cmd_bad;
    logic [LANES-1:0]        w_be_cmd;
    logic [DATA_WIDTH-1:0]   w_wdata_cmd;
    logic [DATA_WIDTH-1:0]   w_shift;
    logic [DATA_WIDTH-1:0]   w_load_val;

    assign w_cmd_bad = (size == 2'd3)
                    || ((size == 2'd2) && (addr_lsb != '0))
                    || ((size == 2'd1) && addr_lsb[0]);

    always_comb begin
        w_be_cmd    = '1;
        w_wdata_cmd = r_data;
        case (size)
            2'd0: begin
                w_be_cmd    = LANES'(1) << addr_lsb;
                w_wdata_cmd = {LANES{r_data[7:0]}};
            end
            2'd1: begin
                w_be_cmd    = LANES'(3) << addr_lsb;
                w_wdata_cmd = {(LANES/2){r_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Full-width loads are always aligned, so the shift is zero for them.
    assign w_shift = mem_rdata >> {r_lsb, 3'b000};

    always_comb begin
        w_load_val = w_shift;
        case (r_size)
            2'd0: w_load_val = {{(DATA_WIDTH-8){w_shift[7] & ~r_unsigned}}, w_shift[7:0]};
            2'd1: w_load_val = {{(DATA_WIDTH-16){w_shift[15] & ~r_unsigned}}, w_shift[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_data_nxt     = r_data;
        w_req_nxt      = r_req;
        w_we_nxt       = r_we;
        w_be_nxt       = r_be;
        w_wdata_nxt    = r_wdata;
        w_cnt_nxt      = r_cnt;
        w_size_nxt     = r_size;
        w_lsb_nxt      = r_lsb;
        w_unsigned_nxt = r_unsigned;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_read && mem_write) begin
                    w_err_nxt = 1'b1;
                end else if ((mem_read || mem_write) && w_cmd_bad) begin
                    w_err_nxt = 1'b1;
                end else if (mem_read || mem_write) begin
                    w_state_nxt    = mem_read ? S_RD_REQ : S_WR_REQ;
                    w_req_nxt      = 1'b1;
                    w_we_nxt       = mem_write;
                    w_be_nxt       = w_be_cmd;
                    w_wdata_nxt    = mem_write ? w_wdata_cmd : '0;
                    w_cnt_nxt      = '0;
                    w_size_nxt     = size;
                    w_lsb_nxt      = addr_lsb;
                    w_unsigned_nxt = unsigned_ld;
                end else if (mdr_in) begin
                    w_data_nxt = bus_in;
                end
            end
            S_RD_REQ, S_WR_REQ: begin
                if (mem_ack || (r_cnt == c_cnt_last)) begin
                    w_state_nxt = S_IDLE;
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_be_nxt    = '0;
                    w_wdata_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = mem_ack;
                    w_err_nxt   = ~mem_ack;
                    if (mem_ack && (r_state == S_RD_REQ)) begin
                        w_data_nxt = w_load_val;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
                w_we_nxt    = 1'b0;
                w_be_nxt    = '0;
                w_wdata_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= 2'd0;
            r_lsb      <= '0;
            r_unsigned <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_data     <= w_data_nxt;
            r_req      <= w_req_nxt;
            r_we       <= w_we_nxt;
            r_be       <= w_be_nxt;
            r_wdata    <= w_wdata_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_size     <= w_size_nxt;
            r_lsb      <= w_lsb_nxt;
            r_unsigned <= w_unsigned_nxt;
        end
    end

    assign bus_out    = mdr_out ? r_data : '0;
    assign bus_out_en = mdr_out;
    assign mem_req    = r_req;
    assign mem_we     = r_we;
    assign mem_be     = r_be;
    assign mem_wdata  = r_wdata;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire
